disp_mux_ctrl: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment display controller.
//  - Accepts a binary value on a load strobe.
//  - Converts it to BCD with an iterative shift-add-3 engine, so no combinational divide/modulo.
//  - Scans the result onto a common-anode display, with leading-zero blanking,
//    per-digit decimal points and an overflow indication.
//  - Sits between measurement blocks (frequency counter etc.) and the board's anode/cathode pins.

---
 rtl/disp_pkg.sv | 62 ++++++
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/disp_mux_ctrl.sv | 148 ++++++++++++++
 tb/tb_disp_mux_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display controller.
// Segment codes are active-low with bit 0 = segment a and bit 6 = segment g.
package disp_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   function automatic int clog2(input longint unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 63; i++) begin
         if ((64'd1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int bcd_width(input int num_digits);
      return 4 * num_digits;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per cycle for BIN_W cycles.
// done and bcd are combinational during the final shift so the caller commits on that edge.
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int BIN_W      = 16,
   parameter int NUM_DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [BIN_W-1:0]          value,
   output logic                      busy,
   output logic                      done,
   output logic [4*NUM_DIGITS-1:0]   bcd,
   output logic                      overflow
);

   localparam int              BCD_W   = bcd_width(NUM_DIGITS);
   localparam int              CNT_W   = clog2(longint'(BIN_W) + 64'd1);
   localparam longint unsigned LIMIT   = pow10(NUM_DIGITS);
   localparam bit              OVF_REACHABLE =
      (BIN_W >= 64) || (((64'd1 << BIN_W) - 64'd1) >= LIMIT);

   logic [BIN_W-1:0] sreg_r;
   logic [BCD_W-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             ovf_r;
   logic [BCD_W-1:0] adj_s;
   logic [BCD_W-1:0] acc_next_s;
   logic             done_s;

   // add-3 correction; carries out of the top digit are simply dropped
   always_comb begin
      adj_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (acc_r[4*i +: 4] >= 4'd5) begin
            adj_s[4*i +: 4] = acc_r[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = acc_r[4*i +: 4];
         end
      end
      acc_next_s = {adj_s[BCD_W-2:0], sreg_r[BIN_W-1]};
      done_s     = busy_r && (cnt_r == CNT_W'(BIN_W - 1));
   end

   // engine state: capture on start, then shift until the last bit is consumed
   always_ff @(posedge clk) begin
      if (reset) begin
         sreg_r <= '0;
         acc_r  <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (busy_r) begin
         sreg_r <= sreg_r << 1;
         acc_r  <= acc_next_s;
         cnt_r  <= cnt_r + CNT_W'(1);
         if (done_s) begin
            busy_r <= 1'b0;
         end else begin
            busy_r <= 1'b1;
         end
      end else if (start) begin
         sreg_r <= value;
         acc_r  <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b1;
         ovf_r  <= OVF_REACHABLE && (64'(value) >= LIMIT);
      end else begin
         busy_r <= 1'b0;
      end
   end

   assign busy     = busy_r;
   assign done     = done_s;
   assign bcd      = acc_next_s;
   assign overflow = ovf_r;

endmodule

// File: rtl/disp_mux_ctrl.sv
// N-digit multiplexed common-anode 7-segment controller with sequential BCD conversion,
// leading-zero blanking, per-digit decimal points and overflow dashes.
module disp_mux_ctrl
   import disp_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int BIN_W        = 16,
   parameter int REFRESH_BITS = 19,
   parameter int BLANK_LZ     = 1
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic [BIN_W-1:0]      value,
   input  logic                  load,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   output logic                  busy,
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] digits,
   output logic [6:0]            segments,
   output logic                  dp
);

   localparam int BCD_W = bcd_width(NUM_DIGITS);
   localparam int IDX_W = (NUM_DIGITS > 1) ? clog2(longint'(NUM_DIGITS)) : 1;

   logic                    eng_busy_s;
   logic                    eng_done_s;
   logic                    eng_ovf_s;
   logic [BCD_W-1:0]        eng_bcd_s;
   logic                    start_s;
   logic [NUM_DIGITS-1:0]   dp_pend_r;
   logic [BCD_W-1:0]        buf_bcd_r;
   logic [NUM_DIGITS-1:0]   buf_dp_r;
   logic                    buf_ovf_r;
   logic [REFRESH_BITS-1:0] refresh_r;
   logic [IDX_W-1:0]        idx_r;
   logic [NUM_DIGITS-1:0]   keep_s;
   logic                    lead_s;
   logic [3:0]              cur_digit_s;
   logic [6:0]              seg_s;
   logic                    dp_s;
   logic [NUM_DIGITS-1:0]   anode_s;
   logic [NUM_DIGITS-1:0]   digits_r;
   logic [6:0]              segments_r;
   logic                    dp_r;

   assign start_s = load && !eng_busy_s;

   bin2bcd_seq #(
      .BIN_W      (BIN_W),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_bin2bcd (
      .clk      (CLK),
      .reset    (reset),
      .start    (start_s),
      .value    (value),
      .busy     (eng_busy_s),
      .done     (eng_done_s),
      .bcd      (eng_bcd_s),
      .overflow (eng_ovf_s)
   );

   // display buffer changes only on the conversion's final edge, all fields together
   always_ff @(posedge CLK) begin
      if (reset) begin
         dp_pend_r <= '0;
         buf_bcd_r <= '0;
         buf_dp_r  <= '0;
         buf_ovf_r <= 1'b0;
      end else begin
         if (start_s) begin
            dp_pend_r <= dp_mask;
         end else begin
            dp_pend_r <= dp_pend_r;
         end
         if (eng_done_s) begin
            buf_bcd_r <= eng_bcd_s;
            buf_dp_r  <= dp_pend_r;
            buf_ovf_r <= eng_ovf_s;
         end else begin
            buf_bcd_r <= buf_bcd_r;
            buf_dp_r  <= buf_dp_r;
            buf_ovf_r <= buf_ovf_r;
         end
      end
   end

   // free-running refresh counter; scan index steps on each wrap
   always_ff @(posedge CLK) begin
      if (reset) begin
         refresh_r <= '0;
         idx_r     <= '0;
      end else begin
         refresh_r <= refresh_r + REFRESH_BITS'(1);
         if (&refresh_r) begin
            if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
               idx_r <= '0;
            end else begin
               idx_r <= idx_r + IDX_W'(1);
            end
         end else begin
            idx_r <= idx_r;
         end
      end
   end

   // keep_s[i]: some digit at or above i is non-zero or carries a decimal point
   always_comb begin
      lead_s      = 1'b0;
      keep_s      = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lead_s    = lead_s | (buf_bcd_r[4*i +: 4] != 4'd0) | buf_dp_r[i];
         keep_s[i] = lead_s;
      end
      cur_digit_s = buf_bcd_r[{idx_r, 2'b00} +: 4];
      anode_s     = ~(NUM_DIGITS'(1) << idx_r);
      if (buf_ovf_r) begin
         seg_s = SEG_DASH;
         dp_s  = 1'b1;
      end else if ((BLANK_LZ != 0) && (idx_r != '0) && !keep_s[idx_r]) begin
         seg_s = SEG_BLANK;
         dp_s  = 1'b1;
      end else begin
         seg_s = seg_decode(cur_digit_s);
         dp_s  = ~buf_dp_r[idx_r];
      end
   end

   // registered pin drivers
   always_ff @(posedge CLK) begin
      if (reset) begin
         digits_r   <= '1;
         segments_r <= SEG_BLANK;
         dp_r       <= 1'b1;
      end else begin
         digits_r   <= anode_s;
         segments_r <= seg_s;
         dp_r       <= dp_s;
      end
   end

   assign busy     = eng_busy_s;
   assign overflow = buf_ovf_r;
   assign digits   = digits_r;
   assign segments = segments_r;
   assign dp       = dp_r;

endmodule

// File: tb/tb_disp_mux_ctrl.sv
// Randomised plus directed bench for disp_mux_ctrl against a decimal-arithmetic display model.
module tb_disp_mux_ctrl;

   logic        CLK;
   logic        reset;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp_mask;
   logic        busy;
   logic        overflow;
   logic [3:0]  digits;
   logic [6:0]  segments;
   logic        dp;

   int n_checks = 0;
   int n_errors = 0;

   // model state: edges since reset, conversion countdown, pending and shown values
   int          m_n    = 0;
   int          m_left = 0;
   int          m_pv   = 0;
   logic [3:0]  m_pm   = 4'd0;
   int          m_val  = 0;
   logic [3:0]  m_dpm  = 4'd0;

   int    p10[5]    = '{1, 10, 100, 1000, 10000};
   string glyph[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                        "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

   disp_mux_ctrl #(
      .NUM_DIGITS   (4),
      .BIN_W        (16),
      .REFRESH_BITS (2),
      .BLANK_LZ     (1)
   ) dut (
      .CLK      (CLK),
      .reset    (reset),
      .value    (value),
      .load     (load),
      .dp_mask  (dp_mask),
      .busy     (busy),
      .overflow (overflow),
      .digits   (digits),
      .segments (segments),
      .dp       (dp)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // active-low pattern from the list of lit segment letters
   function automatic logic [6:0] seg_of(input string lit);
      logic [6:0] on;
      on = 7'd0;
      for (int i = 0; i < lit.len(); i++) begin
         on[int'(lit[i]) - 97] = 1'b1;
      end
      return ~on;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit ld, input int v, input logic [3:0] m);
      logic [3:0] e_dig;
      logic [6:0] e_seg;
      logic       e_dp;
      int         idx;
      reset   = rst;
      load    = ld;
      value   = 16'(v);
      dp_mask = m;
      @(posedge CLK);
      if (rst) begin
         e_dig  = 4'hF;
         e_seg  = 7'h7F;
         e_dp   = 1'b1;
         m_n    = 0;
         m_left = 0;
         m_val  = 0;
         m_dpm  = 4'd0;
      end else begin
         idx   = (m_n / 4) % 4;
         e_dig = ~(4'b0001 << idx);
         if (m_val >= 10000) begin
            e_seg = seg_of("g");
            e_dp  = 1'b1;
         end else if (idx > 0 && m_val < p10[idx] && (m_dpm >> idx) == 4'd0) begin
            e_seg = 7'h7F;
            e_dp  = 1'b1;
         end else begin
            e_seg = seg_of(glyph[(m_val / p10[idx]) % 10]);
            e_dp  = !m_dpm[idx];
         end
         m_n++;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_val = m_pv;
               m_dpm = m_pm;
            end
         end else if (ld) begin
            m_pv   = v;
            m_pm   = m;
            m_left = 16;
         end
      end
      #1;
      check("busy", busy, m_left > 0);
      check("overflow", overflow, m_val >= 10000);
      check("digits", digits, e_dig);
      check("segments", segments, e_seg);
      check("dp", dp, e_dp);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 4'd0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 4'd0);
      idle(20);
      // 1234 shows all digits
      step(1'b0, 1'b1, 1234, 4'd0);
      idle(40);
      // 7 blanked, then 7 with a decimal point on digit 2
      step(1'b0, 1'b1, 7, 4'd0);
      idle(36);
      step(1'b0, 1'b1, 7, 4'b0100);
      idle(36);
      // overflow boundary on both sides
      step(1'b0, 1'b1, 10000, 4'b1111);
      idle(36);
      step(1'b0, 1'b1, 9999, 4'b0001);
      idle(36);
      // loads during conversion and on the commit edge are dropped
      for (int j = 0; j < 40; j++) begin
         if (j == 0)       step(1'b0, 1'b1, 12, 4'd0);
         else if (j == 5)  step(1'b0, 1'b1, 99, 4'd0);
         else if (j == 16) step(1'b0, 1'b1, 55, 4'd0);
         else              step(1'b0, 1'b0, 0, 4'd0);
      end
      // reset mid-conversion, then a fresh load
      step(1'b0, 1'b1, 500, 4'd0);
      idle(7);
      step(1'b1, 1'b0, 0, 4'd0);
      idle(20);
      step(1'b0, 1'b1, 42, 4'd0);
      idle(36);
      for (int i = 0; i < 600; i++) begin
         bit rst;
         bit ld;
         int v;
         rst = ($urandom_range(0, 99) == 0);
         ld  = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 65535));
            1:       v = int'($urandom_range(0, 99));
            default: v = int'($urandom_range(0, 9999));
         endcase
         step(rst, ld, v, 4'($urandom_range(0, 15)));
      end
      idle(40);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
